// File: rtl/sipo_pingpong.sv
// sipo_pingpong: serial-in/parallel-out frame buffer with two ping-pong banks.
// Beats of lanes_p elements fill one bank while the other bank holds a
// complete frame on a valid/yumi output.
// Optional build macro: SIPO_FLUSH_EN (adds flush_i for early frame close and
// zero-masks elements at or above count_o on data_o).
module sipo_pingpong #(
  parameter int width_p = 8,
  parameter int depth_p = 128,
  parameter int lanes_p = 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [lanes_p*width_p-1:0]   data_i,
  output logic                         valid_o,
  input  logic                         yumi_i,
`ifdef SIPO_FLUSH_EN
  input  logic                         flush_i,
`endif
  output logic [width_p*depth_p-1:0]   data_o,
  output logic [$clog2(depth_p+1)-1:0] count_o
);

  localparam int ptr_w = $clog2(depth_p);
  localparam int cnt_w = $clog2(depth_p+1);

  if (((depth_p % lanes_p) != 0) || (depth_p < 2*lanes_p)) begin : g_bad_params
    $error("sipo_pingpong: depth_p must be a multiple of lanes_p and >= 2*lanes_p");
  end

  logic [width_p-1:0]        mem_q [2][depth_p];
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [ptr_w-1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]                full_q, full_d;
  logic [1:0][cnt_w-1:0]     cnt_q, cnt_d;

  logic             accept;
  logic             last_beat;
  logic             flush_close;
  logic             close;
  logic             yumi_eff;
  logic [cnt_w-1:0] close_cnt;

  assign ready_o   = ~full_q[wr_bank_q];
  assign accept    = valid_i & ready_o;
  assign last_beat = (wr_ptr_q == ptr_w'(depth_p - lanes_p));
  assign yumi_eff  = yumi_i & full_q[rd_bank_q];

`ifdef SIPO_FLUSH_EN
  // Early close needs something written, either already or on this beat.
  assign flush_close = flush_i & ((wr_ptr_q != '0) | accept);
`else
  assign flush_close = 1'b0;
`endif

  assign close     = (accept & last_beat) | flush_close;
  assign close_cnt = accept ? (cnt_w'(wr_ptr_q) + cnt_w'(lanes_p)) : cnt_w'(wr_ptr_q);

  // Next-state: consume frees the read bank, close fills the write bank.
  // They never target the same bank in one cycle, so both may apply.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    full_d    = full_q;
    cnt_d     = cnt_q;
    if (yumi_eff) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (close) begin
      full_d[wr_bank_q] = 1'b1;
      cnt_d[wr_bank_q]  = close_cnt;
      wr_bank_d         = ~wr_bank_q;
      wr_ptr_d          = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + ptr_w'(lanes_p);
    end
  end

  // Control state register; reset drops any partial or held frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      full_q    <= '0;
      cnt_q     <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
    end
  end

  // Bank storage, written one beat of lanes at a time; not reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int k = 0; k < lanes_p; k++) begin
        mem_q[wr_bank_q][wr_ptr_q + ptr_w'(k)] <= data_i[k*width_p +: width_p];
      end
    end
  end

  assign valid_o = full_q[rd_bank_q];
  assign count_o = valid_o ? cnt_q[rd_bank_q] : '0;

  // Flatten the read bank onto data_o, element 0 in the low bits.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < depth_p; i++) begin
`ifdef SIPO_FLUSH_EN
      if (cnt_w'(i) < cnt_q[rd_bank_q]) begin
        data_o[i*width_p +: width_p] = mem_q[rd_bank_q][i];
      end
`else
      data_o[i*width_p +: width_p] = mem_q[rd_bank_q][i];
`endif
    end
  end

endmodule

// File: tb/tb_sipo_pingpong.sv
// Self-checking bench for sipo_pingpong (width 8, depth 4; lanes 1 and lanes 2).
module tb_sipo_pingpong;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        valid = 1'b0;
  logic        yumi = 1'b0;
  logic [7:0]  din = '0;
  logic        ready_o, valid_o;
  logic [31:0] dout;
  logic [2:0]  cnt;

  logic        valid2 = 1'b0;
  logic        yumi2 = 1'b0;
  logic [15:0] din2 = '0;
  logic        ready2, vo2;
  logic [31:0] dout2;
  logic [2:0]  cnt2;

`ifdef SIPO_FLUSH_EN
  logic flush = 1'b0;
  logic flush2 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic [31:0] part = '0;
  int          part_n = 0;

  always #5 clk = ~clk;

  sipo_pingpong #(.width_p(8), .depth_p(4), .lanes_p(1)) u_dut (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .ready_o(ready_o), .data_i(din),
    .valid_o(valid_o), .yumi_i(yumi),
`ifdef SIPO_FLUSH_EN
    .flush_i(flush),
`endif
    .data_o(dout), .count_o(cnt));

  sipo_pingpong #(.width_p(8), .depth_p(4), .lanes_p(2)) u_dut2 (
    .clk_i(clk), .reset_i(rst), .valid_i(valid2), .ready_o(ready2), .data_i(din2),
    .valid_o(vo2), .yumi_i(yumi2),
`ifdef SIPO_FLUSH_EN
    .flush_i(flush2),
`endif
    .data_o(dout2), .count_o(cnt2));

  // One clock of stimulus on u_dut; the scoreboard follows the reference
  // behaviour: accept while fewer than two frames are held, consume on yumi.
  task automatic cycle1(input logic v, input logic [7:0] d, input logic y);
    logic acc, yum;
    valid = v; din = d; yumi = y;
    acc = v && (sb_q.size() < 2);
    yum = y && (sb_q.size() > 0);
    @(posedge clk); #1;
    if (yum) void'(sb_q.pop_front());
    if (acc) begin
      part[part_n*8 +: 8] = d;
      part_n++;
      if (part_n == 4) begin
        sb_q.push_back(part);
        part_n = 0;
      end
    end
    valid = 1'b0; yumi = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_o); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", cnt); end
    checks++; if (vo2 !== 1'b0 || ready2 !== 1'b1) begin errors++; $display("FAIL rst_dut2 got v=%b r=%b want v=0 r=1", vo2, ready2); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL post_rst got r=%b v=%b want r=1 v=0", ready_o, valid_o); end
  endtask

  task automatic test_basic();
    cycle1(1'b1, 8'h11, 1'b0);
    cycle1(1'b1, 8'h22, 1'b0);
    cycle1(1'b1, 8'h33, 1'b0);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", valid_o); end
    cycle1(1'b1, 8'h44, 1'b0);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", valid_o); end
    checks++; if (dout !== sb_q[0]) begin errors++; $display("FAIL basic_data got %h want %h", dout, sb_q[0]); end
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL basic_count got %0d want 4", cnt); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", ready_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] first;
    first = sb_q[0];
    for (int i = 0; i < 8; i++) begin
      cycle1(1'b1, 8'h55 + 8'(i) * 8'h11, 1'b0);
      checks++; if (valid_o !== 1'b1 || dout !== first) begin errors++; $display("FAIL hold_frame beat %0d got v=%b %h want v=1 %h", i, valid_o, dout, first); end
    end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL both_full_ready got %b want 0", ready_o); end
    yumi = 1'b1; #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL ready_in_yumi_cycle got %b want 0", ready_o); end
    cycle1(1'b0, 8'h00, 1'b1);
    checks++; if (valid_o !== 1'b1 || dout !== sb_q[0]) begin errors++; $display("FAIL frame2 got v=%b %h want v=1 %h", valid_o, dout, sb_q[0]); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_yumi got %b want 1", ready_o); end
    cycle1(1'b0, 8'h00, 1'b1);
    checks++; if (valid_o !== 1'b0 || cnt !== 3'd0) begin errors++; $display("FAIL drained got v=%b c=%0d want v=0 c=0", valid_o, cnt); end
  endtask

  task automatic test_lanes2();
    logic [31:0] exp2;
    exp2 = '0;
    valid2 = 1'b1; din2 = 16'h2211; exp2[15:0] = din2;
    @(posedge clk); #1;
    checks++; if (vo2 !== 1'b0) begin errors++; $display("FAIL l2_early_valid got %b want 0", vo2); end
    din2 = 16'h4433; exp2[31:16] = din2;
    @(posedge clk); #1;
    valid2 = 1'b0;
    checks++; if (vo2 !== 1'b1 || dout2 !== exp2) begin errors++; $display("FAIL l2_frame got v=%b %h want v=1 %h", vo2, dout2, exp2); end
    checks++; if (cnt2 !== 3'd4) begin errors++; $display("FAIL l2_count got %0d want 4", cnt2); end
    yumi2 = 1'b1;
    @(posedge clk); #1;
    yumi2 = 1'b0;
    checks++; if (vo2 !== 1'b0) begin errors++; $display("FAIL l2_consume got %b want 0", vo2); end
  endtask

  task automatic test_random_stream();
    int consumed = 0;
    int cyc = 0;
    logic v, y;
    while (consumed < 64 && cyc < 4000) begin
      checks++; if (ready_o !== (sb_q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, ready_o, sb_q.size() < 2); end
      checks++; if (valid_o !== (sb_q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, valid_o, sb_q.size() > 0); end
      if (sb_q.size() > 0) begin
        checks++; if (dout !== sb_q[0] || cnt !== 3'd4) begin errors++; $display("FAIL rnd_frame cyc %0d got %h c=%0d want %h c=4", cyc, dout, cnt, sb_q[0]); end
      end
      v = ($urandom_range(0, 3) != 0);
      y = (sb_q.size() > 0) && ($urandom_range(0, 1) == 1);
      if (y) consumed++;
      cycle1(v, 8'($urandom), y);
      cyc++;
    end
    checks++; if (consumed < 64) begin errors++; $display("FAIL rnd_timeout got %0d frames want 64", consumed); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); rst = 1'b1; #2 rst = 1'b0;
    sb_q.delete(); part_n = 0;
    for (int i = 1; i <= 6; i++) cycle1(1'b1, 8'(i), 1'b0);
    checks++; if (valid_o !== 1'b1 || dout !== sb_q[0]) begin errors++; $display("FAIL mid_pre got v=%b %h want v=1 %h", valid_o, dout, sb_q[0]); end
    #3 rst = 1'b1; #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || cnt !== 3'd0) begin errors++; $display("FAIL mid_async got v=%b r=%b c=%0d want v=0 r=1 c=0", valid_o, ready_o, cnt); end
    sb_q.delete(); part_n = 0;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle1(1'b1, 8'hA1 + 8'(i), 1'b0);
      if (i == 2) begin
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_partial got %b want 0", valid_o); end
      end
    end
    checks++; if (valid_o !== 1'b1 || dout !== sb_q[0] || cnt !== 3'd4) begin errors++; $display("FAIL mid_clean got v=%b %h c=%0d want v=1 %h c=4", valid_o, dout, cnt, sb_q[0]); end
    cycle1(1'b0, 8'h00, 1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_drain got %b want 0", valid_o); end
  endtask

`ifdef SIPO_FLUSH_EN
  task automatic push_flushed();
    logic [31:0] exp;
    exp = '0;
    for (int i = 0; i < part_n; i++) exp[i*8 +: 8] = part[i*8 +: 8];
    sb_q.push_back(exp);
    part_n = 0;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    cycle1(1'b0, 8'h00, 1'b0);
    flush = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_idle got %b want 0", valid_o); end
    cycle1(1'b1, 8'hAA, 1'b0);
    flush = 1'b1;
    cycle1(1'b1, 8'hBB, 1'b0);
    flush = 1'b0;
    push_flushed();
    checks++; if (valid_o !== 1'b1 || cnt !== 3'd2) begin errors++; $display("FAIL flush_cnt got v=%b c=%0d want v=1 c=2", valid_o, cnt); end
    checks++; if (dout !== sb_q[0]) begin errors++; $display("FAIL flush_data got %h want %h", dout, sb_q[0]); end
    cycle1(1'b1, 8'hCC, 1'b1);
    flush = 1'b1;
    cycle1(1'b0, 8'h00, 1'b0);
    flush = 1'b0;
    push_flushed();
    checks++; if (valid_o !== 1'b1 || cnt !== 3'd1 || dout !== sb_q[0]) begin errors++; $display("FAIL flush_ptr got v=%b c=%0d %h want v=1 c=1 %h", valid_o, cnt, dout, sb_q[0]); end
    cycle1(1'b0, 8'h00, 1'b1);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_lanes2();
    test_random_stream();
    test_reset_mid();
`ifdef SIPO_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_pingpong.md
Name: sipo_pingpong

Overview:
Parameterised serial-in/parallel-out buffer, successor to the single-bank SIPO. It accepts lanes_p elements per beat on a valid/ready input. It assembles depth_p-element frames in two ping-pong banks, so the input keeps filling one bank while a full frame is held on the output. The full frame is presented on a valid/yumi output. It feeds the systolic array's row/column loaders from the UART/SPI byte stream.

Parameters:
width_p, 8, bits per element
depth_p, 128, elements per frame; must be a multiple of lanes_p and >= 2*lanes_p (elaboration error otherwise)
lanes_p, 1, elements accepted per input beat (1, 2, 4 ...)

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-high reset
valid_i  in  1  input beat valid
ready_o  out  1  input can accept a beat; registered, no combinational path from any input
data_i  in  lanes_p*width_p  beat payload; lane k at bits [(k+1)*width_p-1 : k*width_p]
valid_o  out  1  frame available on data_o
yumi_i  in  1  consumer takes the frame this cycle; legal only while valid_o=1
data_o  out  width_p*depth_p  frame; element i at bits [(i+1)*width_p-1 : i*width_p], element 0 received first
count_o  out  $clog2(depth_p+1)  valid elements in the presented frame

Behaviour:
- State: two banks mem[2][depth_p]; wr_bank_r, rd_bank_r (1 bit each); wr_ptr_r (element index, steps by lanes_p); full_r[1:0]; cnt_r[2] per bank.
- Reset (async, asserted): wr_bank_r=0, rd_bank_r=0, wr_ptr_r=0, full_r=0, cnt_r=0. Outputs during and after reset: ready_o=1, valid_o=0, count_o=0. Bank storage is not reset.
- ready_o = ~full_r[wr_bank_r].
- Accept = valid_i & ready_o. On accept, lane k is written to mem[wr_bank_r][wr_ptr_r+k] and wr_ptr_r += lanes_p.
- Frame close: on the accept that writes element depth_p-1:
  - full_r[wr_bank_r] <= 1, cnt_r[wr_bank_r] <= depth_p;
  - wr_bank_r toggles, wr_ptr_r <= 0.
- Output: valid_o = full_r[rd_bank_r]; data_o = mem[rd_bank_r]; count_o = valid_o ? cnt_r[rd_bank_r] : 0.
- Consume: on yumi_i, full_r[rd_bank_r] <= 0 and rd_bank_r toggles. yumi_i while valid_o=0 is ignored; no state changes.
- Latency: the closing beat accepted at edge N gives valid_o=1 immediately after edge N. The frame is held stable until the yumi edge.
- Both banks full: ready_o=0. A yumi at edge N frees that bank, and ready_o=1 after edge N. ready_o does not rise in the same cycle as yumi_i.
- Simultaneous close of one bank and yumi of the other in the same cycle: both take effect, and valid_o stays 1 with the new bank.
- Pointer and bank indices wrap modulo depth_p and modulo 2 respectively, with no lost or duplicated beats across any number of frames.
- Reset asserted mid-frame: the partial frame is discarded, and any held frame is dropped (valid_o=0 asynchronously).

Optional Feature:
SIPO_FLUSH_EN
- Defined: adds port flush_i (in, 1).
  - flush_i=1 with wr_ptr_r!=0, or with an accept in the same cycle, closes the current bank early. Then cnt = elements written including this cycle's beat, full is set, the bank toggles and wr_ptr_r <= 0.
  - flush_i with wr_ptr_r=0 and no accept is ignored.
  - Elements at index >= count_o are driven as zero on data_o, masked at the output.
- Not defined: no flush_i port. count_o equals depth_p whenever valid_o=1, and no masking logic is built.

Test Plan:
- Reset, then lanes_p=1, depth_p=4, feed 0x11,0x22,0x33,0x44 back-to-back -> valid_o=1 after 4th edge, data_o=0x44332211, count_o=4.
- Same config, hold yumi_i=0 and stream 8 more beats -> ready_o=0 after 8 total beats, valid_o stays 1 with frame 0x44332211 unchanged. Pulse yumi -> frame 2 presented next cycle, ready_o=1 the cycle after yumi.
- lanes_p=2, depth_p=4, beats 0x2211, 0x4433 -> data_o=0x44332211 after 2nd edge.
- Continuous stream of 64 frames with random valid_i/yumi_i (no illegal yumi) -> scoreboard exact, in-order frames, no drops.
- Assert reset_i mid-frame (2 of 4 elements written, one frame held) -> valid_o=0 and ready_o=1 immediately. The next 4 elements form a clean frame.
- SIPO_FLUSH_EN, depth_p=4: feed 0xAA, 0xBB with flush_i on the 2nd beat -> valid_o=1, count_o=2, data_o=0x0000BBAA.
